multicycle_controller: RTL and testbench

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

---
 rtl/multicycle_controller.sv | 197 +++++++++++++++++++
 tb/tb_multicycle_controller.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// Multicycle RISC-V style control FSM: sequences fetch/decode/execute/writeback strobes and counts retired instructions.
// Optional feature: define JAL_EN to support the JAL opcode (otherwise it is treated as unsupported).
module multicycle_controller #(
    parameter int unsigned CNT_W           = 32,
    parameter int unsigned HOLD_ON_ILLEGAL = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       op,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             adr_src,
    output logic             ir_write,
    output logic             mem_read,
    output logic             mem_write,
    output logic             reg_write,
    output logic             branch,
    output logic [1:0]       result_src,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       imm_src,
    output logic             illegal,
    output logic [CNT_W-1:0] instret,
    output logic [3:0]       state
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_ALUWB    = 4'd7,
        S_EXECUTEI = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10,
        S_TRAP     = 4'd11
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] instret_q, instret_d;

    logic is_lw, is_sw, is_r, is_i, is_beq, is_jal, supported;
    logic pc_update, retire;
    logic ir_write_c, mem_read_c, mem_write_c, reg_write_c, branch_c;

    assign is_lw  = (op == OP_LW);
    assign is_sw  = (op == OP_SW);
    assign is_r   = (op == OP_R);
    assign is_i   = (op == OP_I);
    assign is_beq = (op == OP_BEQ);
`ifdef JAL_EN
    assign is_jal = (op == OP_JAL);
`else
    assign is_jal = 1'b0;
`endif
    assign supported = is_lw | is_sw | is_r | is_i | is_beq | is_jal;

    always_comb begin
        imm_src = 2'b00;
        if (is_sw)       imm_src = 2'b01;
        else if (is_beq) imm_src = 2'b10;
        else if (is_jal) imm_src = 2'b11;
    end

    always_comb begin
        state_d     = state_q;
        pc_update   = 1'b0;
        retire      = 1'b0;
        adr_src     = 1'b0;
        ir_write_c  = 1'b0;
        mem_read_c  = 1'b0;
        mem_write_c = 1'b0;
        reg_write_c = 1'b0;
        branch_c    = 1'b0;
        result_src  = 2'b00;
        alu_src_a   = 2'b00;
        alu_src_b   = 2'b00;
        alu_op      = 2'b00;
        illegal     = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_read_c = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                // The instruction register and PC only advance on the cycle memory delivers.
                if (mem_ready) begin
                    ir_write_c = 1'b1;
                    pc_update  = 1'b1;
                    state_d    = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                illegal   = ~supported;
                if (is_lw || is_sw) state_d = S_MEMADR;
                else if (is_r)      state_d = S_EXECUTER;
                else if (is_i)      state_d = S_EXECUTEI;
                else if (is_jal)    state_d = S_JAL;
                else if (is_beq)    state_d = S_BEQ;
                else                state_d = (HOLD_ON_ILLEGAL != 0) ? S_TRAP : S_FETCH;
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                state_d   = is_sw ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                adr_src    = 1'b1;
                mem_read_c = 1'b1;
                if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                result_src  = 2'b01;
                reg_write_c = 1'b1;
                retire      = 1'b1;
                state_d     = S_FETCH;
            end
            S_MEMWRITE: begin
                adr_src     = 1'b1;
                mem_write_c = 1'b1;
                if (mem_ready) begin
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_EXECUTER: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b10;
                state_d   = S_ALUWB;
            end
            S_EXECUTEI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = 2'b10;
                state_d   = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write_c = 1'b1;
                retire      = 1'b1;
                state_d     = S_FETCH;
            end
            S_JAL: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_update = 1'b1;
                state_d   = S_ALUWB;
            end
            S_BEQ: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b01;
                branch_c  = 1'b1;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end
            S_TRAP: begin
                illegal = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase
    end

    assign instret_d = retire ? instret_q + CNT_W'(1) : instret_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            instret_q <= instret_d;
        end
    end

    // Reset parks the FSM in FETCH, whose strobes must still be silenced while rst_n is low.
    assign pc_write  = rst_n & (pc_update | (branch_c & zero));
    assign ir_write  = rst_n & ir_write_c;
    assign mem_read  = rst_n & mem_read_c;
    assign mem_write = rst_n & mem_write_c;
    assign reg_write = rst_n & reg_write_c;
    assign branch    = rst_n & branch_c;
    assign instret   = instret_q;
    assign state     = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench: instruction-level trace model vs two controllers (trap-hold and skip variants, 8-bit counter).
module tb_multicycle_controller;

    typedef struct packed {
        logic       pcw, adr, irw, mrd, mwr, rw, br, ill;
        logic [1:0] rs, sa, sb, ao, imm;
    } outs_t;

    logic       clk = 1'b0, rst_n = 1'b0, zero = 1'b0, mem_ready = 1'b0;
    logic [6:0] op = 7'd0;

    logic       pc_write, adr_src, ir_write, mem_read, mem_write, reg_write, branch, illegal;
    logic [1:0] result_src, alu_src_a, alu_src_b, alu_op, imm_src;
    logic [7:0] instret;
    logic [3:0] state;

    logic       d2_pcw, d2_adr, d2_irw, d2_mrd, d2_mwr, d2_rw, d2_br, d2_ill;
    logic [1:0] d2_rs, d2_sa, d2_sb, d2_ao, d2_imm;
    logic [7:0] d2_instret;
    logic [3:0] d2_state;

    multicycle_controller #(.CNT_W(8), .HOLD_ON_ILLEGAL(1)) dut (
        .clk(clk), .rst_n(rst_n), .op(op), .zero(zero), .mem_ready(mem_ready),
        .pc_write(pc_write), .adr_src(adr_src), .ir_write(ir_write), .mem_read(mem_read),
        .mem_write(mem_write), .reg_write(reg_write), .branch(branch),
        .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .imm_src(imm_src), .illegal(illegal), .instret(instret), .state(state)
    );

    multicycle_controller #(.CNT_W(8), .HOLD_ON_ILLEGAL(0)) dut_skip (
        .clk(clk), .rst_n(rst_n), .op(op), .zero(zero), .mem_ready(mem_ready),
        .pc_write(d2_pcw), .adr_src(d2_adr), .ir_write(d2_irw), .mem_read(d2_mrd),
        .mem_write(d2_mwr), .reg_write(d2_rw), .branch(d2_br),
        .result_src(d2_rs), .alu_src_a(d2_sa), .alu_src_b(d2_sb),
        .alu_op(d2_ao), .imm_src(d2_imm), .illegal(d2_ill), .instret(d2_instret), .state(d2_state)
    );

    always #5 clk = ~clk;

    outs_t got;
    assign got = {pc_write, adr_src, ir_write, mem_read, mem_write, reg_write, branch, illegal,
                  result_src, alu_src_a, alu_src_b, alu_op, imm_src};

    int ncmp = 0, nerr = 0;
    int cnt = 0;

    localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011,
                           IA = 7'b0010011, BQ = 7'b1100011, JL = 7'b1101111;

    function automatic bit supported(logic [6:0] o);
`ifdef JAL_EN
        return o inside {LW, SW, RT, IA, BQ, JL};
`else
        return o inside {LW, SW, RT, IA, BQ};
`endif
    endfunction

    // Expected output bundle straight from the per-state output table.
    function automatic outs_t exp_out(int st, bit mr, bit z, logic [6:0] o);
        outs_t e = '0;
        case (st)
            0:  begin e.mrd = 1; e.sb = 2; e.rs = 2; e.irw = mr; end
            1:  begin e.sa = 1; e.sb = 1; end
            2:  begin e.sa = 2; e.sb = 1; end
            3:  begin e.adr = 1; e.mrd = 1; end
            4:  begin e.rs = 1; e.rw = 1; end
            5:  begin e.adr = 1; e.mwr = 1; end
            6:  begin e.sa = 2; e.ao = 2; end
            7:  e.rw = 1;
            8:  begin e.sa = 2; e.sb = 1; e.ao = 2; end
            9:  begin e.sa = 1; e.sb = 2; end
            10: begin e.sa = 2; e.ao = 1; e.br = 1; end
            default: ;
        endcase
        e.pcw = (st == 0 && mr) || st == 9 || (st == 10 && z);
        e.ill = (st == 11) || (st == 1 && !supported(o));
        if (o == SW)      e.imm = 2'b01;
        else if (o == BQ) e.imm = 2'b10;
        else if (o == JL && supported(o)) e.imm = 2'b11;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [63:0] g, input logic [63:0] e);
        ncmp++;
        assert (g === e) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, g, e);
        end
    endtask

    function automatic bit rb();
        return 1'($urandom_range(0, 1));
    endfunction

    // One clock: drive inputs on the falling edge, check just after, retire credited at the next rise.
    task automatic cyc(input int st, input bit mr, input bit z, input bit ret, input bit chk2);
        @(negedge clk);
        mem_ready = mr;
        zero = z;
        #1;
        chk($sformatf("state@%0d", st), 64'(state), 64'(st));
        chk($sformatf("instret@%0d", st), 64'(instret), 64'(cnt));
        chk($sformatf("outs@%0d", st), 64'(got), 64'(exp_out(st, mr, z, op)));
        if (chk2) chk($sformatf("skip_state@%0d", st), 64'(d2_state), 64'(st));
        if (ret) cnt = (cnt + 1) % 256;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        mem_ready = 1'b0;
        #1;
        cnt = 0;
        chk("rst_state", 64'({state, d2_state}), 64'(0));
        chk("rst_instret", 64'({instret, d2_instret}), 64'(0));
        chk("rst_strobes", 64'({pc_write, ir_write, mem_read, mem_write, reg_write, branch,
                                d2_pcw, d2_irw, d2_mrd, d2_mwr, d2_rw, d2_br}), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // kind: 0 LW, 1 SW, 2 R, 3 I-ALU, 4 BEQ, 5 JAL, 6 unsupported (o used)
    task automatic run_instr(input int kind, input int fw, input int mw, input bit bz, input logic [6:0] o);
        case (kind)
            0: op = LW;  1: op = SW;  2: op = RT;
            3: op = IA;  4: op = BQ;  5: op = JL;
            default: op = o;
        endcase
        repeat (fw) cyc(0, 0, rb(), 0, 1);
        cyc(0, 1, rb(), 0, 1);
        cyc(1, rb(), rb(), 0, 1);
        if (!supported(op)) begin
            cyc(11, rb(), rb(), 0, 0);
            chk("skip_refetch", 64'(d2_state), 64'(0));
            repeat (9) cyc(11, rb(), rb(), 0, 0);
            do_reset();
        end else begin
            case (kind)
                0: begin
                    cyc(2, rb(), rb(), 0, 1);
                    repeat (mw) cyc(3, 0, rb(), 0, 1);
                    cyc(3, 1, rb(), 0, 1);
                    cyc(4, rb(), rb(), 1, 1);
                end
                1: begin
                    cyc(2, rb(), rb(), 0, 1);
                    repeat (mw) cyc(5, 0, rb(), 0, 1);
                    cyc(5, 1, rb(), 1, 1);
                end
                2: begin cyc(6, rb(), rb(), 0, 1); cyc(7, rb(), rb(), 1, 1); end
                3: begin cyc(8, rb(), rb(), 0, 1); cyc(7, rb(), rb(), 1, 1); end
                4: cyc(10, rb(), bz, 1, 1);
                default: begin cyc(9, rb(), rb(), 0, 1); cyc(7, rb(), rb(), 1, 1); end
            endcase
        end
    endtask

    initial begin
        #500000;
        $error("FAIL watchdog: simulation did not finish within time budget");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [6:0] bad_ops [4];
        bad_ops = '{7'b1111111, 7'b0000000, 7'b0110111, 7'b1100111};

        repeat (2) @(negedge clk);
        do_reset();

        run_instr(0, 0, 0, 0, 0);          // LW, memory always ready
        run_instr(1, 0, 3, 0, 0);          // SW, three stall cycles in MEMWRITE
        run_instr(4, 0, 0, 1, 0);          // BEQ taken
        run_instr(4, 0, 0, 0, 0);          // BEQ not taken
        run_instr(2, 1, 0, 0, 0);
        run_instr(3, 2, 0, 0, 0);
        run_instr(0, 1, 2, 0, 0);
        run_instr(5, 0, 0, 0, 0);          // JAL: traps unless JAL_EN
        run_instr(6, 0, 0, 0, 7'b1111111);

        // Reset asserted while stalled in MEMREAD
        op = LW;
        cyc(0, 1, 0, 0, 1);
        cyc(1, 1, 0, 0, 1);
        cyc(2, 1, 0, 0, 1);
        cyc(3, 0, 0, 0, 1);
        do_reset();

        // Counter wrap: 256 back-to-back R-type instructions, four cycles each
        for (int i = 0; i < 256; i++) run_instr(2, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        chk("wrap_instret", 64'(instret), 64'(0));

        for (int i = 0; i < 300; i++)
            run_instr($urandom_range(0, 6), $urandom_range(0, 2), $urandom_range(0, 3), rb(),
                      bad_ops[$urandom_range(0, 3)]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
